// File: rtl/exp_result_fifo.sv
// Result FIFO between the accelerator controller and its consumer: circular buffer with a registered read port, one-cycle read latency.
// No backpressure upstream; writes to a full FIFO are dropped and flagged, reads from an empty FIFO are ignored and flagged.
module exp_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count_nxt;
  logic             rd_acc;
  logic             wr_acc;
  logic             ovf_evt;
  logic             unf_evt;

  // A full FIFO still takes a write when the same-cycle read frees a slot.
  always_comb begin
    rd_acc  = rd_req && !empty;
    wr_acc  = wr_req && (!full || rd_acc);
    ovf_evt = wr_req && !wr_acc;
    unf_evt = rd_req && empty;
  end

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // full/empty are decodes of this state register, so they track the next-state count.
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: begin
        if (wr_acc) state_nxt = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (wr_acc && !rd_acc && count == CNT_LAST)
          state_nxt = S_FULL;
        else if (rd_acc && !wr_acc && count == CNT_ONE)
          state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (rd_acc && !wr_acc) state_nxt = S_PARTIAL;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  assign full  = (state == S_FULL);
  assign empty = (state == S_EMPTY);

  // Storage is left unreset; empty after reset keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      rd_valid <= rd_acc;
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) begin
        rp      <= rp + 1'b1;
        rd_data <= mem[rp];
      end
      // A new error in the clearing cycle wins over the clear.
      overflow  <= (overflow  && !clr_err) || ovf_evt;
      underflow <= (underflow && !clr_err) || unf_evt;
    end
  end

endmodule
